// File: rtl/ic74138_grant_decoder_if.sv
// Signal bundle between the ic74148-based request front end and the grant decoder.
// The master drives encoder outputs, gating and ack; the slave returns grant/status.
interface ic74138_grant_decoder_if;
    logic [2:0] Y_bar;
    logic       GS_bar;
    logic       G1;
    logic       G2A_bar;
    logic       G2B_bar;
    logic       ack;
    logic [7:0] Q_bar;
    logic [2:0] code_out;
    logic       busy;
    logic       idle;
    logic       err;

    modport master (
        output Y_bar, GS_bar, G1, G2A_bar, G2B_bar, ack,
        input  Q_bar, code_out, busy, idle, err
    );

    modport slave (
        input  Y_bar, GS_bar, G1, G2A_bar, G2B_bar, ack,
        output Q_bar, code_out, busy, idle, err
    );
endinterface

// File: rtl/ic74138_grant_decoder.sv
// Sequential 74138-style grant decoder: captures encoded requests, serves the highest
// pending index with a hold phase, an ack handshake and an optional ack timeout.
module ic74138_grant_decoder #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input logic                    clk,
    input logic                    rst,
    ic74138_grant_decoder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StDrive, StWaitAck} state_e;

    state_e     state_q, state_d;
    logic [2:0] code_q, code_p_q;
    logic       gs_q, gs_p_q;
    logic [7:0] pending_q, pending_d;
    logic [2:0] cur_q, cur_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] q_bar_q;
    logic [2:0] code_out_q;
    logic       busy_q, idle_q, err_q;

    logic       enable;
    logic       new_req;
    logic [2:0] sel;
    logic       clr;
    logic       timeout_hit;

    assign enable  = bus.G1 & ~bus.G2A_bar & ~bus.G2B_bar;
    // A held code raises one request; a change of code or a fresh GS edge raises another.
    assign new_req = enable & gs_q & (~gs_p_q | (code_q != code_p_q));

    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending_q[i]) begin
                sel = 3'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        clr         = 1'b0;
        timeout_hit = 1'b0;
        if (!enable) begin
            // Abort keeps the pending bit so the request is served again later.
            state_d = StIdle;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pending_q != 8'd0) begin
                        cur_d   = sel;
                        cnt_d   = 8'(HOLD_CYCLES);
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = StWaitAck;
                        cnt_d   = 8'(TIMEOUT);
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                StWaitAck: begin
                    if (bus.ack) begin
                        clr     = 1'b1;
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end else if (TIMEOUT != 0) begin
                        if (cnt_q <= 8'd1) begin
                            clr         = 1'b1;
                            timeout_hit = 1'b1;
                            state_d     = StIdle;
                            cnt_d       = 8'd0;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Set after clear so a request landing on the completing index survives.
    always_comb begin
        pending_d = pending_q;
        if (clr) begin
            pending_d[cur_q] = 1'b0;
        end
        if (new_req) begin
            pending_d[code_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            code_q     <= 3'd0;
            code_p_q   <= 3'd0;
            gs_q       <= 1'b0;
            gs_p_q     <= 1'b0;
            pending_q  <= 8'd0;
            cur_q      <= 3'd0;
            cnt_q      <= 8'd0;
            q_bar_q    <= 8'hFF;
            code_out_q <= 3'd0;
            busy_q     <= 1'b0;
            idle_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= ~bus.Y_bar;
            code_p_q   <= code_q;
            gs_q       <= ~bus.GS_bar;
            gs_p_q     <= gs_q;
            pending_q  <= pending_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            q_bar_q    <= (state_d != StIdle) ? ~(8'd1 << cur_d) : 8'hFF;
            code_out_q <= cur_d;
            busy_q     <= (state_d != StIdle);
            idle_q     <= (state_q == StIdle) && (pending_q == 8'd0);
            err_q      <= timeout_hit;
        end
    end

    assign bus.Q_bar    = q_bar_q;
    assign bus.code_out = code_out_q;
    assign bus.busy     = busy_q;
    assign bus.idle     = idle_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_ic74138_grant_decoder.sv
// Bench for ic74138_grant_decoder: directed scenarios plus random traffic, every cycle
// compared against a time-based behavioural model of the grant service.
module tb_ic74138_grant_decoder;
    localparam int HOLD = 2;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ic74138_grant_decoder_if bus();

    ic74138_grant_decoder #(
        .HOLD_CYCLES(HOLD),
        .TIMEOUT    (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: registered input history, pending set, current grant and its age in cycles.
    logic [2:0] m_code_r, m_code_p;
    logic       m_gs_r, m_gs_p;
    bit         m_pend[8];
    int         m_gnt = -1;
    int         m_age = 0;
    logic [7:0] m_q = 8'hFF;
    logic [2:0] m_code_out = 3'd0;
    logic       m_busy = 1'b0, m_idle = 1'b1, m_err = 1'b0;

    int         grants[$];
    logic [7:0] prev_q = 8'hFF;
    int         err_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit en, req, was_idle, none;
        int clr, top;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_gnt = -1; m_age = 0;
            m_code_r = 3'd0; m_code_p = 3'd0; m_gs_r = 1'b0; m_gs_p = 1'b0;
            m_q = 8'hFF; m_code_out = 3'd0; m_busy = 1'b0; m_idle = 1'b1; m_err = 1'b0;
            return;
        end
        en  = bus.G1 && !bus.G2A_bar && !bus.G2B_bar;
        req = en && m_gs_r && (!m_gs_p || (m_code_r != m_code_p));
        was_idle = (m_gnt < 0);
        none = 1'b1;
        top  = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i]) begin
                none = 1'b0;
                top  = i;
            end
        end
        clr   = -1;
        m_err = 1'b0;
        if (!en) begin
            m_gnt = -1;
        end else if (m_gnt < 0) begin
            if (!none) begin
                m_gnt = top;
                m_age = 0;
            end
        end else begin
            m_age++;
            if (m_age > HOLD) begin
                if (bus.ack) begin
                    clr = m_gnt; m_gnt = -1;
                end else if (TMO != 0 && m_age == HOLD + TMO) begin
                    clr = m_gnt; m_gnt = -1; m_err = 1'b1;
                end
            end
        end
        if (clr >= 0) m_pend[clr] = 1'b0;
        if (req) m_pend[m_code_r] = 1'b1;
        m_q = (m_gnt < 0) ? 8'hFF : ~(8'd1 << m_gnt);
        if (m_gnt >= 0) m_code_out = 3'(m_gnt);
        m_busy = (m_gnt >= 0);
        m_idle = was_idle && none;
        m_code_p = m_code_r; m_gs_p = m_gs_r;
        m_code_r = ~bus.Y_bar; m_gs_r = ~bus.GS_bar;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("q_bar", 32'(bus.Q_bar), 32'(m_q));
        check_eq("code_out", 32'(bus.code_out), 32'(m_code_out));
        check_eq("busy", 32'(bus.busy), 32'(m_busy));
        check_eq("idle", 32'(bus.idle), 32'(m_idle));
        check_eq("err", 32'(bus.err), 32'(m_err));
        if (prev_q == 8'hFF && bus.Q_bar != 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
                if (!bus.Q_bar[i]) grants.push_back(i);
            end
        end
        if (bus.err) err_count++;
        prev_q = bus.Q_bar;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int idx, input bit valid);
        bus.Y_bar  = ~3'(idx);
        bus.GS_bar = !valid;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.ack = 1'b0; bus.GS_bar = 1'b1;
        bus.G1 = 1'b1; bus.G2A_bar = 1'b0; bus.G2B_bar = 1'b0;
        ticks(2);
        rst = 1'b0;
        grants.delete();
        err_count = 0;
    endtask

    initial begin
        bus.G1 = 1'b1; bus.G2A_bar = 1'b0; bus.G2B_bar = 1'b0; bus.ack = 1'b0;
        set_req(7, 1'b1);

        // Reset with an active request on the inputs: nothing may be granted.
        rst = 1'b1;
        ticks(2);
        check_eq("rst_q_bar", 32'(bus.Q_bar), 32'hFF);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_idle", 32'(bus.idle), 32'd1);
        check_eq("rst_err", 32'(bus.err), 32'd0);
        check_eq("rst_no_grant", 32'(grants.size()), 32'd0);

        // Single grant of index 5, acked after four cycles.
        do_reset();
        set_req(5, 1'b1);
        ticks(3);
        check_eq("single_q_bar", 32'(bus.Q_bar), 32'hDF);
        check_eq("single_code", 32'(bus.code_out), 32'd5);
        ticks(3);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check_eq("single_release", 32'(bus.Q_bar), 32'hFF);
        tick();
        check_eq("single_idle", 32'(bus.idle), 32'd1);

        // Priority: 2 in service, then 1 and 6 arrive; 6 must be served before 1.
        do_reset();
        set_req(2, 1'b1); ticks(4);
        set_req(1, 1'b1); ticks(3);
        set_req(6, 1'b1); ticks(3);
        bus.GS_bar = 1'b1; bus.ack = 1'b1;
        ticks(20);
        bus.ack = 1'b0;
        check_eq("prio_count", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            check_eq("prio_first", 32'(grants[0]), 32'd2);
            check_eq("prio_second", 32'(grants[1]), 32'd6);
            check_eq("prio_third", 32'(grants[2]), 32'd1);
        end

        // Held code for 30 cycles yields one grant.
        do_reset();
        set_req(3, 1'b1);
        for (int i = 0; i < 30; i++) begin
            bus.ack = (i == 8);
            tick();
        end
        bus.ack = 1'b0;
        check_eq("held_count", 32'(grants.size()), 32'd1);
        if (grants.size() == 1) check_eq("held_index", 32'(grants[0]), 32'd3);

        // Timeout on index 0 with no ack.
        do_reset();
        set_req(0, 1'b1); ticks(3);
        bus.GS_bar = 1'b1;
        ticks(25);
        check_eq("tmo_err_pulses", 32'(err_count), 32'd1);
        check_eq("tmo_idle", 32'(bus.idle), 32'd1);

        // Enable drop during WAIT_ACK, ignored request while disabled, re-grant, set-wins.
        do_reset();
        set_req(4, 1'b1); ticks(3);
        bus.GS_bar = 1'b1; ticks(3);
        bus.G2A_bar = 1'b1;
        tick();
        check_eq("drop_q_bar", 32'(bus.Q_bar), 32'hFF);
        check_eq("drop_busy", 32'(bus.busy), 32'd0);
        check_eq("drop_idle", 32'(bus.idle), 32'd0);
        set_req(7, 1'b1); ticks(3);
        bus.GS_bar = 1'b1; ticks(2);
        check_eq("drop_ignored", 32'(grants.size()), 32'd1);
        bus.G2A_bar = 1'b0;
        ticks(3);
        set_req(4, 1'b1); tick();
        bus.ack = 1'b1; tick();
        bus.ack = 1'b0; bus.GS_bar = 1'b1;
        ticks(3);
        check_eq("regrant_count", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            check_eq("regrant_index", 32'(grants[1]), 32'd4);
            check_eq("setwins_index", 32'(grants[2]), 32'd4);
        end
        bus.ack = 1'b1; ticks(5);
        bus.ack = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.Y_bar  = 3'($urandom_range(0, 7));
                bus.GS_bar = ($urandom_range(0, 9) < 3);
            end
            bus.G1      = ($urandom_range(0, 19) != 0);
            bus.G2A_bar = ($urandom_range(0, 29) == 0);
            bus.G2B_bar = ($urandom_range(0, 29) == 0);
            bus.ack     = ($urandom_range(0, 4) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
